am386sx_bus_initiator: RTL and testbench
========================================

// Module: am386sx_bus_initiator
// PURPOSE
//  Synthesizable Am386SX-compatible local-bus initiator: turns single commands into 386SX non-pipelined
//  bus cycles (ADS#, M/IO#, D/C#, W/R#, BHE#/BLE#, A23:1, D15:0) and completes them on READY#.
//  Stands in for the CPU on the header bus so northbridge/SDRAM paths run without silicon; also grants HOLD.
//  clk is the CLK2-equivalent: one bus T-state = 2 clk (phase 1, phase 2).
// PARAMETERS
//  TIMEOUT_T   256  T2 states waited for READY# before the cycle is aborted (1..65535)
//  TO_W        16   width of the wait-state counter; must hold TIMEOUT_T
// PORTS
//  clk          in   1   CLK2-rate clock; single clock domain
//  reset        in   1   synchronous, active-high
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1   1 = write (W/R# high)
//  cmd_mio      in   1   1 = memory, 0 = I/O
//  cmd_dc       in   1   1 = data, 0 = control (halt/int-ack)
//  cmd_lock     in   1   assert LOCK# for this cycle
//  cmd_addr     in   23  A23:A1
//  cmd_be_n     in   2   {BHE#, BLE#}; 2'b11 is illegal -> forced to 2'b00
//  cmd_wdata    in   16  write data
//  rsp_valid    out  1   1-clk pulse: cycle finished
//  rsp_rdata    out  16  read data captured with READY# (0 for writes)
//  rsp_timeout  out  1   qualifies rsp_valid: cycle aborted, READY# never seen
//  ads_n        out  1   address strobe, active low
//  wr, dc, mio  out  1   bus cycle definition
//  lock_n       out  1   bus lock, active low
//  be_n         out  2   {BHE#, BLE#}
//  addr         out  23  A23:A1
//  data_o/oe    out  16/1 write data and drive enable for D15:0
//  data_i       in   16  D15:0 sampled on reads
//  ready_n      in   1   cycle termination, sampled at end of T2 phase 2
//  hold         in   1   bus request from another master
//  hlda         out  1   hold acknowledge
//  bus_float    out  1   1 = tri-state all address/control/data outputs
// BEHAVIOUR
//  Reset: state TI; ads_n=1, lock_n=1, be_n=2'b11, wr=dc=mio=0, addr=0, data_oe=0, hlda=0, bus_float=0,
//   cmd_ready=0, rsp_*=0, counter=0. Reset mid-cycle aborts immediately; no rsp_valid emitted.
//  States: TI, T1P1, T1P2, T2P1, T2P2, TH.
//  TI: cmd_ready=1 unless hold=1. hold=1 (priority over cmd_valid in same clk) -> TH.
//   Accept -> latch all cmd_* into registers, go T1P1.
//  T1P1/T1P2: ads_n=0, wr/dc/mio/addr/be_n/lock_n from latched command. -> T2P1.
//  T2P1: ads_n=1; if write, data_oe=1 with data_o=wdata (held through T2P2 of the last T2).
//  T2P2: sample ready_n. ready_n=0 -> rsp_valid=1 next clk, rsp_rdata=data_i if read, go TI.
//   ready_n=1 -> counter++, back to T2P1 (wait state). counter==TIMEOUT_T-1 with ready_n=1 ->
//   rsp_valid=1 & rsp_timeout=1, rsp_rdata=0, go TI.
//  Earliest READY#: 4 clk from accept to sample, rsp_valid on clk 5; next ADS# no sooner than clk 6.
//  lock_n stays low across back-to-back cmd_lock cycles; HOLD is not granted while previous cycle
//   had lock set; lock_n deasserts (1) on first non-lock command or entry to TH request when unlocked.
//  TH: bus_float=1, hlda=1, data_oe=0, cmd_ready=0. hold=0 -> hlda=0, bus_float=0 next clk, TI.
//  hold asserted mid-cycle is ignored until the cycle completes (T2P2 exit), then TI->TH.
//  NA# unsupported: no pipelined addressing. data_oe never 1 during reads or TH.
//  rsp_valid pulses exactly once per accepted command; rsp_timeout=0 whenever rsp_valid=0.
// TESTING
//  1 Read mem 0x000400, be_n=00, ready_n low on first T2 with data_i=16'hBEEF -> ads_n low clks 1-2,
//    mio=1 wr=0, rsp_valid clk 5, rsp_rdata=BEEF, rsp_timeout=0.
//  2 Write I/O 0x0003F8, be_n=10, wdata=16'h00A5, 3 wait states -> data_oe high 8 T2 clks, data_o=00A5,
//    be_n=10, mio=0 wr=1, rsp_valid once after 4th T2P2.
//  3 TIMEOUT_T=4, ready_n held high -> rsp_valid & rsp_timeout after 4 T2 states, rsp_rdata=0, back to TI.
//  4 hold raised during T1P1 of a read -> cycle completes normally, then hlda=1, bus_float=1;
//    cmd_valid held high not accepted until hold drops; hlda falls 1 clk after hold.
//  5 Two back-to-back cmd_lock writes then an unlocked read -> lock_n low continuously across both
//    writes, high on the read's ADS#; hold during locked sequence deferred until lock_n high.
//  6 reset pulsed in T2P1 of a write -> next clk all outputs at reset values, no rsp_valid, data_oe=0.

Source files
------------

// File: rtl/am386sx_bus_initiator.sv
// Am386SX-compatible local-bus initiator: single commands in, non-pipelined
// 386SX bus cycles out (T1/T2 at CLK2 rate), completed on READY# or timeout.
// Ports:
//   clk, reset                  CLK2-rate clock, synchronous active-high reset
//   cmd_*                       command handshake and fields (valid/ready)
//   rsp_valid/rdata/timeout     one-clock completion pulse with read data
//   ads_n, wr, dc, mio, lock_n  bus cycle definition and strobes
//   be_n, addr, data_o/oe       byte enables, A23:A1, write data and drive enable
//   data_i, ready_n             read data and cycle termination from the bus
//   hold, hlda, bus_float       bus arbitration with another master
module am386sx_bus_initiator #(
    parameter int TIMEOUT_T = 256,
    parameter int TO_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_mio,
    input  logic        cmd_dc,
    input  logic        cmd_lock,
    input  logic [22:0] cmd_addr,
    input  logic [1:0]  cmd_be_n,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        ads_n,
    output logic        wr,
    output logic        dc,
    output logic        mio,
    output logic        lock_n,
    output logic [1:0]  be_n,
    output logic [22:0] addr,
    output logic [15:0] data_o,
    output logic        data_oe,
    input  logic [15:0] data_i,
    input  logic        ready_n,
    input  logic        hold,
    output logic        hlda,
    output logic        bus_float
);

    typedef enum logic [2:0] {
        S_TI,
        S_T1P1,
        S_T1P2,
        S_T2P1,
        S_T2P2,
        S_TH
    } state_e;

    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_T - 1);

    state_e          state_q, state_d;
    logic            wr_q, wr_d;
    logic            mio_q, mio_d;
    logic            dc_q, dc_d;
    logic            lock_q, lock_d;
    logic [22:0]     addr_q, addr_d;
    logic [1:0]      be_n_q, be_n_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [15:0]     rsp_rdata_q, rsp_rdata_d;
    logic            in_t1, in_t2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_TI;
            wr_q          <= 1'b0;
            mio_q         <= 1'b0;
            dc_q          <= 1'b0;
            lock_q        <= 1'b0;
            addr_q        <= '0;
            be_n_q        <= 2'b11;
            wdata_q       <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            wr_q          <= wr_d;
            mio_q         <= mio_d;
            dc_q          <= dc_d;
            lock_q        <= lock_d;
            addr_q        <= addr_d;
            be_n_q        <= be_n_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_d          = wr_q;
        mio_d         = mio_q;
        dc_d          = dc_q;
        lock_d        = lock_q;
        addr_d        = addr_q;
        be_n_d        = be_n_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
        cmd_ready     = 1'b0;

        unique case (state_q)
            S_TI: begin
                // A locked sequence keeps the bus: HOLD waits until
                // a command without lock has run.
                if (hold && !lock_q) begin
                    state_d = S_TH;
                end else begin
                    cmd_ready = !reset;
                    if (cmd_valid) begin
                        wr_d    = cmd_write;
                        mio_d   = cmd_mio;
                        dc_d    = cmd_dc;
                        lock_d  = cmd_lock;
                        addr_d  = cmd_addr;
                        // No-byte enable is meaningless; make it a word.
                        be_n_d  = (cmd_be_n == 2'b11) ? 2'b00 : cmd_be_n;
                        wdata_d = cmd_wdata;
                        cnt_d   = '0;
                        state_d = S_T1P1;
                    end
                end
            end
            S_T1P1: state_d = S_T1P2;
            S_T1P2: state_d = S_T2P1;
            S_T2P1: state_d = S_T2P2;
            S_T2P2: begin
                if (!ready_n) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? 16'h0000 : data_i;
                    cnt_d       = '0;
                    state_d     = S_TI;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = S_TI;
                end else begin
                    cnt_d   = cnt_q + TO_W'(1);
                    state_d = S_T2P1;
                end
            end
            S_TH: begin
                if (!hold) state_d = S_TI;
            end
            default: state_d = S_TI;
        endcase
    end

    assign in_t1 = (state_q == S_T1P1) || (state_q == S_T1P2);
    assign in_t2 = (state_q == S_T2P1) || (state_q == S_T2P2);

    assign ads_n       = !in_t1;
    assign wr          = wr_q;
    assign mio         = mio_q;
    assign dc          = dc_q;
    assign lock_n      = !lock_q;
    assign be_n        = be_n_q;
    assign addr        = addr_q;
    assign data_oe     = wr_q && in_t2;
    assign data_o      = data_oe ? wdata_q : 16'h0000;
    assign hlda        = (state_q == S_TH);
    assign bus_float   = (state_q == S_TH);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_am386sx_bus_initiator.sv
// Bench for am386sx_bus_initiator: table of bus commands plus
// hand-written hold, lock and mid-cycle reset sequences.
module tb_am386sx_bus_initiator;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic        cmd_mio;
    logic        cmd_dc;
    logic        cmd_lock;
    logic [22:0] cmd_addr;
    logic [1:0]  cmd_be_n;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_timeout;
    logic        ads_n;
    logic        wr;
    logic        dc;
    logic        mio;
    logic        lock_n;
    logic [1:0]  be_n;
    logic [22:0] addr;
    logic [15:0] data_o;
    logic        data_oe;
    logic [15:0] data_i;
    logic        ready_n;
    logic        hold;
    logic        hlda;
    logic        bus_float;

    int n_vec = 0;
    int n_err = 0;
    logic exp_lock_n;

    typedef struct {
        logic        wr;
        logic        mio;
        logic        dc;
        logic        lock;
        logic [22:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          waits;
        logic [15:0] bus;
        logic [1:0]  exp_be;
        logic [15:0] exp_rdata;
        logic        exp_to;
    } vec_t;

    vec_t tbl[6];
    vec_t v_hold, v_after, v_lk1, v_lk2, v_rd;

    am386sx_bus_initiator #(
        .TIMEOUT_T(TO),
        .TO_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_mio(cmd_mio),
        .cmd_dc(cmd_dc),
        .cmd_lock(cmd_lock),
        .cmd_addr(cmd_addr),
        .cmd_be_n(cmd_be_n),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .ads_n(ads_n),
        .wr(wr),
        .dc(dc),
        .mio(mio),
        .lock_n(lock_n),
        .be_n(be_n),
        .addr(addr),
        .data_o(data_o),
        .data_oe(data_oe),
        .data_i(data_i),
        .ready_n(ready_n),
        .hold(hold),
        .hlda(hlda),
        .bus_float(bus_float)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ads_n"}, ads_n, 1'b1);
        chk({tag, " lock_n"}, lock_n, 1'b1);
        chk({tag, " be_n"}, be_n, 2'b11);
        chk({tag, " wr/dc/mio"}, {wr, dc, mio}, 3'b000);
        chk({tag, " addr"}, addr, 23'h0);
        chk({tag, " data_oe"}, data_oe, 1'b0);
        chk({tag, " hlda/float"}, {hlda, bus_float}, 2'b00);
        chk({tag, " cmd_ready"}, cmd_ready, 1'b0);
        chk({tag, " rsp"}, {rsp_valid, rsp_timeout, rsp_rdata}, 18'h0);
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_mio   = v.mio;
        cmd_dc    = v.dc;
        cmd_lock  = v.lock;
        cmd_addr  = v.addr;
        cmd_be_n  = v.be;
        cmd_wdata = v.wdata;
    endtask

    // Called at a negedge with the DUT idle in TI; returns at the
    // negedge of the response clock.
    task automatic do_cmd(input vec_t v, input bit raise_hold);
        chk("accept ready", cmd_ready, !(hold && exp_lock_n));
        chk("idle lock_n", lock_n, exp_lock_n);
        drive_cmd(v);
        @(negedge clk);
        cmd_valid  = 1'b0;
        exp_lock_n = !v.lock;
        if (raise_hold) hold = 1'b1;
        chk("t1p1 ads_n", ads_n, 1'b0);
        chk("t1p1 def", {mio, wr, dc}, {v.mio, v.wr, v.dc});
        chk("t1p1 addr", addr, v.addr);
        chk("t1p1 be_n", be_n, v.exp_be);
        chk("t1p1 lock_n", lock_n, exp_lock_n);
        chk("t1p1 rsp_valid", rsp_valid, 1'b0);
        chk("t1p1 data_oe", data_oe, 1'b0);
        @(negedge clk);
        chk("t1p2 ads_n", ads_n, 1'b0);
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            chk("t2p1 ads_n", ads_n, 1'b1);
            chk("t2p1 data_oe", data_oe, v.wr);
            if (v.wr) chk("t2p1 data_o", data_o, v.wdata);
            chk("t2p1 lock_n", lock_n, exp_lock_n);
            chk("t2p1 hlda", hlda, 1'b0);
            @(negedge clk);
            chk("t2p2 data_oe", data_oe, v.wr);
            chk("t2p2 rsp_valid", rsp_valid, 1'b0);
            data_i  = v.bus;
            ready_n = (t == v.waits) ? 1'b0 : 1'b1;
            if (t == v.waits || t == TO - 1) break;
        end
        @(negedge clk);
        ready_n = 1'b1;
        data_i  = 16'h0;
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_timeout", rsp_timeout, v.exp_to);
        chk("rsp data_oe", data_oe, 1'b0);
        chk("rsp ads_n", ads_n, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_mio   = 1'b0;
        cmd_dc    = 1'b0;
        cmd_lock  = 1'b0;
        cmd_addr  = '0;
        cmd_be_n  = 2'b11;
        cmd_wdata = '0;
        data_i    = '0;
        ready_n   = 1'b1;
        hold      = 1'b0;
        exp_lock_n = 1'b1;

        tbl[0] = '{wr:0, mio:1, dc:1, lock:0, addr:23'h000400, be:2'b00,
                   wdata:16'h0, waits:0, bus:16'hBEEF, exp_be:2'b00,
                   exp_rdata:16'hBEEF, exp_to:0};
        tbl[1] = '{wr:1, mio:0, dc:1, lock:0, addr:23'h0003F8, be:2'b10,
                   wdata:16'h00A5, waits:3, bus:16'hDEAD, exp_be:2'b10,
                   exp_rdata:16'h0, exp_to:0};
        tbl[2] = '{wr:0, mio:1, dc:1, lock:0, addr:23'h7FFFFF, be:2'b11,
                   wdata:16'h0, waits:1, bus:16'h1234, exp_be:2'b00,
                   exp_rdata:16'h1234, exp_to:0};
        tbl[3] = '{wr:0, mio:1, dc:1, lock:0, addr:23'h123456, be:2'b01,
                   wdata:16'h0, waits:99, bus:16'hFFFF, exp_be:2'b01,
                   exp_rdata:16'h0, exp_to:1};
        tbl[4] = '{wr:1, mio:1, dc:0, lock:0, addr:23'h2AAAAA, be:2'b01,
                   wdata:16'h5A5A, waits:0, bus:16'h0, exp_be:2'b01,
                   exp_rdata:16'h0, exp_to:0};
        tbl[5] = '{wr:0, mio:0, dc:1, lock:0, addr:23'h000060, be:2'b10,
                   wdata:16'h0, waits:2, bus:16'hA55A, exp_be:2'b10,
                   exp_rdata:16'hA55A, exp_to:0};
        v_hold = '{wr:0, mio:1, dc:1, lock:0, addr:23'h001000, be:2'b00,
                   wdata:16'h0, waits:0, bus:16'hC0DE, exp_be:2'b00,
                   exp_rdata:16'hC0DE, exp_to:0};
        v_after = '{wr:0, mio:1, dc:1, lock:0, addr:23'h001001, be:2'b00,
                    wdata:16'h0, waits:1, bus:16'h4321, exp_be:2'b00,
                    exp_rdata:16'h4321, exp_to:0};
        v_lk1 = '{wr:1, mio:1, dc:1, lock:1, addr:23'h000200, be:2'b00,
                  wdata:16'h1111, waits:0, bus:16'h0, exp_be:2'b00,
                  exp_rdata:16'h0, exp_to:0};
        v_lk2 = '{wr:1, mio:1, dc:1, lock:1, addr:23'h000201, be:2'b00,
                  wdata:16'h2222, waits:1, bus:16'h0, exp_be:2'b00,
                  exp_rdata:16'h0, exp_to:0};
        v_rd = '{wr:0, mio:1, dc:1, lock:0, addr:23'h000202, be:2'b00,
                 wdata:16'h0, waits:0, bus:16'h3333, exp_be:2'b00,
                 exp_rdata:16'h3333, exp_to:0};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle cmd_ready", cmd_ready, 1'b1);
        chk("idle ads_n", ads_n, 1'b1);

        for (int i = 0; i < 6; i++) do_cmd(tbl[i], 1'b0);
        @(negedge clk);
        chk("pulse end", {rsp_valid, rsp_timeout}, 2'b00);

        // hold raised during T1P1: cycle completes, then TH
        do_cmd(v_hold, 1'b1);
        chk("hold ready", cmd_ready, 1'b0);
        drive_cmd(v_after);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("th hlda/float", {hlda, bus_float}, 2'b11);
            chk("th cmd_ready", cmd_ready, 1'b0);
            chk("th data_oe", data_oe, 1'b0);
        end
        hold = 1'b0;
        @(negedge clk);
        chk("hold drop hlda", {hlda, bus_float}, 2'b00);
        do_cmd(v_after, 1'b0);

        // locked pair with hold pending, then unlocked read
        do_cmd(v_lk1, 1'b1);
        do_cmd(v_lk2, 1'b0);
        do_cmd(v_rd, 1'b0);
        chk("unlock ready", cmd_ready, 1'b0);
        @(negedge clk);
        chk("unlock hlda", hlda, 1'b1);
        hold = 1'b0;
        @(negedge clk);
        chk("unlock hlda drop", hlda, 1'b0);

        // reset in T2P1 of a write
        drive_cmd(tbl[1]);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre-reset data_oe", data_oe, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post-reset rsp", rsp_valid, 1'b0);
            chk("post-reset oe", data_oe, 1'b0);
        end
        chk("post-reset ready", cmd_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
